// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

    // Register-file index width and the hardwired-zero register.
    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    // Controller state: normal flow or mult/div unit occupied.
    typedef enum logic {
        StRun,
        StMdBusy
    } hz_state_e;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up-counter that sticks at its maximum value instead of wrapping.
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;
    logic [31:0] w_count_nxt;

    // Next count: increment when enabled unless already saturated.
    always_comb begin
        w_count_nxt = r_count;
        if (i_en && (r_count != 32'hFFFF_FFFF)) begin
            w_count_nxt = r_count + 32'd1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'd0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a five-stage MIPS pipeline: load-use stalls,
// branch redirect flushes, mult/div structural stalls and a stall counter.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = $clog2(MD_LATENCY)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 IDEX_MemRead,
    input  logic [REG_IDX_W-1:0] IDEX_Rt,
    input  logic [REG_IDX_W-1:0] IFID_Rs,
    input  logic [REG_IDX_W-1:0] IFID_Rt,
    input  logic                 IFID_UsesRt,
    input  logic                 IFID_UsesHiLo,
    input  logic                 Branch_Taken,
    input  logic                 MD_Start,
    output logic                 PC_Write,
    output logic                 IFID_Write,
    output logic                 IFID_Flush,
    output logic                 IDEX_Flush,
    output logic                 MD_Busy,
    output logic                 MD_Done,
    output logic                 MD_Overlap,
    output logic [31:0]          Stall_Cycles
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_overlap;
    logic             w_overlap_nxt;

    logic w_load_use;
    logic w_busy;
    logic w_md_hazard;
    logic w_stall;

    // Load in EX targets a register the ID instruction reads; $zero never hazards.
    assign w_load_use = IDEX_MemRead && (IDEX_Rt != ZERO_REG) &&
                        ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign w_busy      = (r_state == StMdBusy);
    assign w_md_hazard = w_busy && IFID_UsesHiLo;
    assign w_stall     = w_load_use || w_md_hazard;

    // Pipeline control: stall wins over a taken branch, which stays held in ID.
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        if (w_stall) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (Branch_Taken) begin
            IFID_Flush = 1'b1;
        end
    end

    // Mult/div occupancy FSM; a start while busy is flagged but otherwise ignored.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_overlap_nxt = r_overlap;
        unique case (r_state)
            StRun: begin
                if (MD_Start) begin
                    w_state_nxt = StMdBusy;
                    w_count_nxt = CNT_LOAD;
                end
            end
            StMdBusy: begin
                if (MD_Start) begin
                    w_overlap_nxt = 1'b1;
                end
                if (r_count == '0) begin
                    w_state_nxt = StRun;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
            default: begin
                w_state_nxt = StRun;
            end
        endcase
    end

    // State, countdown and sticky overlap flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= StRun;
            r_count   <= '0;
            r_overlap <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_overlap <= w_overlap_nxt;
        end
    end

    assign MD_Busy    = w_busy;
    assign MD_Done    = w_busy && (r_count == '0);
    assign MD_Overlap = r_overlap;

    sat_counter32 u_stall_cnt (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_en    (w_stall),
        .o_count (Stall_Cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with MD_LATENCY = 4.
module tb_pipeline_hazard_ctrl;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        IFID_UsesHiLo;
    logic        Branch_Taken;
    logic        MD_Start;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        MD_Busy;
    logic        MD_Done;
    logic        MD_Overlap;
    logic [31:0] Stall_Cycles;

    int n_total = 0;
    int n_bad   = 0;

    pipeline_hazard_ctrl #(
        .MD_LATENCY (4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_Rt       (IDEX_Rt),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_UsesRt   (IFID_UsesRt),
        .IFID_UsesHiLo (IFID_UsesHiLo),
        .Branch_Taken  (Branch_Taken),
        .MD_Start      (MD_Start),
        .PC_Write      (PC_Write),
        .IFID_Write    (IFID_Write),
        .IFID_Flush    (IFID_Flush),
        .IDEX_Flush    (IDEX_Flush),
        .MD_Busy       (MD_Busy),
        .MD_Done       (MD_Done),
        .MD_Overlap    (MD_Overlap),
        .Stall_Cycles  (Stall_Cycles)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset         = 1'b0;
        IDEX_MemRead  = 1'b0;
        IDEX_Rt       = 5'd0;
        IFID_Rs       = 5'd0;
        IFID_Rt       = 5'd0;
        IFID_UsesRt   = 1'b0;
        IFID_UsesHiLo = 1'b0;
        Branch_Taken  = 1'b0;
        MD_Start      = 1'b0;

        // Reset state
        repeat (2) @(negedge Clock);
        #1;
        check_val("rst_pcw", 32'(PC_Write), 32'd1);
        check_val("rst_ifw", 32'(IFID_Write), 32'd1);
        check_val("rst_iff", 32'(IFID_Flush), 32'd0);
        check_val("rst_idf", 32'(IDEX_Flush), 32'd0);
        check_val("rst_busy", 32'(MD_Busy), 32'd0);
        check_val("rst_ovl", 32'(MD_Overlap), 32'd0);
        check_val("rst_cnt", Stall_Cycles, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Load-use on Rs: one stall cycle
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
        #1;
        check_val("lu_pcw", 32'(PC_Write), 32'd0);
        check_val("lu_ifw", 32'(IFID_Write), 32'd0);
        check_val("lu_idf", 32'(IDEX_Flush), 32'd1);
        check_val("lu_iff", 32'(IFID_Flush), 32'd0);
        @(negedge Clock);
        IDEX_MemRead = 1'b0;
        #1;
        check_val("lu_rel_pcw", 32'(PC_Write), 32'd1);
        check_val("lu_cnt", Stall_Cycles, 32'd1);

        // Zero register and Rt-use gating (no edges taken while stalling)
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
        #1;
        check_val("zero_pcw", 32'(PC_Write), 32'd1);
        check_val("zero_idf", 32'(IDEX_Flush), 32'd0);
        IDEX_Rt = 5'd9; IFID_Rs = 5'd3; IFID_Rt = 5'd9; IFID_UsesRt = 1'b0;
        #1;
        check_val("rt_unused_pcw", 32'(PC_Write), 32'd1);
        IFID_UsesRt = 1'b1;
        #1;
        check_val("rt_used_pcw", 32'(PC_Write), 32'd0);
        IDEX_MemRead = 1'b0; IFID_UsesRt = 1'b0;
        @(negedge Clock);
        #1;
        check_val("zero_cnt", Stall_Cycles, 32'd1);

        // Branch alone, then branch under load-use
        Branch_Taken = 1'b1;
        #1;
        check_val("br_iff", 32'(IFID_Flush), 32'd1);
        check_val("br_pcw", 32'(PC_Write), 32'd1);
        check_val("br_idf", 32'(IDEX_Flush), 32'd0);
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
        #1;
        check_val("brlu_iff", 32'(IFID_Flush), 32'd0);
        check_val("brlu_idf", 32'(IDEX_Flush), 32'd1);
        check_val("brlu_pcw", 32'(PC_Write), 32'd0);
        IDEX_MemRead = 1'b0; Branch_Taken = 1'b0; IFID_Rs = 5'd0;
        @(negedge Clock);

        // Mult/div busy window with HI/LO consumer waiting in ID
        MD_Start = 1'b1; IFID_UsesHiLo = 1'b1;
        #1;
        check_val("md_issue_pcw", 32'(PC_Write), 32'd1);
        check_val("md_issue_busy", 32'(MD_Busy), 32'd0);
        @(negedge Clock);
        MD_Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("md_busy%0d", i), 32'(MD_Busy), 32'd1);
            check_val($sformatf("md_done%0d", i), 32'(MD_Done), (i == 3) ? 32'd1 : 32'd0);
            check_val($sformatf("md_pcw%0d", i), 32'(PC_Write), 32'd0);
            @(negedge Clock);
        end
        #1;
        check_val("md_rel_busy", 32'(MD_Busy), 32'd0);
        check_val("md_rel_pcw", 32'(PC_Write), 32'd1);
        check_val("md_cnt", Stall_Cycles, 32'd5);
        IFID_UsesHiLo = 1'b0;

        // Overlap: start held from busy cycle 2 through done and into RUN
        MD_Start = 1'b1;
        @(negedge Clock);
        MD_Start = 1'b0;
        #1;
        check_val("ovl_none", 32'(MD_Overlap), 32'd0);
        @(negedge Clock);
        MD_Start = 1'b1;
        @(negedge Clock);
        #1;
        check_val("ovl_set", 32'(MD_Overlap), 32'd1);
        check_val("ovl_busy3", 32'(MD_Busy), 32'd1);
        check_val("ovl_done3", 32'(MD_Done), 32'd0);
        @(negedge Clock);
        #1;
        check_val("ovl_done4", 32'(MD_Done), 32'd1);
        @(negedge Clock);
        #1;
        check_val("ovl_run_busy", 32'(MD_Busy), 32'd0);
        @(negedge Clock);
        MD_Start = 1'b0;
        #1;
        check_val("b2b_busy", 32'(MD_Busy), 32'd1);
        check_val("b2b_done", 32'(MD_Done), 32'd0);

        // Asynchronous reset mid-busy
        #2 Reset = 1'b0;
        #1;
        check_val("arst_busy", 32'(MD_Busy), 32'd0);
        check_val("arst_ovl", 32'(MD_Overlap), 32'd0);
        check_val("arst_cnt", Stall_Cycles, 32'd0);
        check_val("arst_pcw", 32'(PC_Write), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;

        // Saturation from a preloaded count
        force dut.u_stall_cnt.r_count = 32'hFFFF_FFFE;
        #1 release dut.u_stall_cnt.r_count;
        #1;
        check_val("sat_pre", Stall_Cycles, 32'hFFFF_FFFE);
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            #1;
            check_val($sformatf("sat%0d", i), Stall_Cycles, 32'hFFFF_FFFF);
        end
        IDEX_MemRead = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. Each cycle it decides the write-enable of the PC and IF/ID register and the flush inputs of the IF/ID and ID/EX stage registers. It covers three cases: load-use hazards, taken branches/jumps resolved in ID, and structural stalls while the multi-cycle multiply/divide unit is busy. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue (legal 2..64)
- CNT_W, $clog2(MD_LATENCY), width of the busy countdown

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low; all state cleared while low
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  5  load destination register in EX
- IFID_Rs  in  5  source register of instruction in ID
- IFID_Rt  in  5  second source register of instruction in ID
- IFID_UsesRt  in  1  instruction in ID reads Rt
- IFID_UsesHiLo  in  1  instruction in ID is MFHI/MFLO/MULT/DIV
- Branch_Taken  in  1  branch or jump in ID redirects PC
- MD_Start  in  1  mult/div issued in EX this cycle
- PC_Write  out  1  PC load enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  IF/ID flush
- IDEX_Flush  out  1  ID/EX flush (bubble insert)
- MD_Busy  out  1  mult/div unit occupied
- MD_Done  out  1  last busy cycle
- MD_Overlap  out  1  sticky error: MD_Start while busy
- Stall_Cycles  out  32  saturating count of stall cycles

## Operation
- States: RUN, MD_BUSY. Reset → RUN, countdown 0, MD_Overlap 0, Stall_Cycles 0.
- load_use = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & IDEX_Rt == IFID_Rt)).
- md_hazard = (state == MD_BUSY) & IFID_UsesHiLo.
- stall = load_use | md_hazard. When stall: PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0.
- When not stall and Branch_Taken: PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=0.
- Otherwise: PC_Write=1, IFID_Write=1, both flushes 0.
- Stall beats Branch_Taken. The branch stays held in ID and is re-evaluated next cycle.
- RUN with MD_Start → MD_BUSY, countdown ← MD_LATENCY-1.
- MD_BUSY: countdown decrements each edge. When countdown == 0, MD_Done=1, and the next edge returns to RUN.
- MD_Start in MD_BUSY is ignored: state and countdown are unchanged, and MD_Overlap is set. MD_Overlap clears only on reset.
- Stall_Cycles increments on every edge where stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- PC_Write, IFID_Write, both flushes and MD_Done are combinational (Mealy) from the current state and inputs. They take effect at the next rising edge in the stage registers.
- A load-use stall lasts exactly one cycle. On the next cycle the load has moved to MEM, so IDEX_MemRead drops.
- MD_Busy=1 for MD_LATENCY cycles, starting the cycle after the MD_Start edge. MD_Done is high in the last of those cycles.
- Back-to-back issue is allowed: MD_Start in the MD_Done cycle is still an overlap, and MD_Start in the following RUN cycle is accepted.
- Reset asserted mid-busy returns the block to RUN immediately, asynchronously. With the block idle, outputs become PC_Write=1, IFID_Write=1, both flushes 0.

## Structure
- Shared package pipeline_pkg: state enum (RUN, MD_BUSY), register-index width (5), the zero-register constant.
- Single flat module plus one sub-module, sat_counter32 (enable, async active-low reset, saturate at max), for Stall_Cycles.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 → one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1; Stall_Cycles=1.
- Zero register: IDEX_MemRead=1, IDEX_Rt=0, IFID_Rs=0 → no stall. IFID_UsesRt=0 with a matching Rt only → no stall.
- Branch alone: Branch_Taken=1 → IFID_Flush=1, PC_Write=1. Branch_Taken with load_use → stall outputs only, IFID_Flush=0.
- Mult/div, MD_LATENCY=4: MD_Start pulse → MD_Busy high for 4 cycles, MD_Done on the 4th. IFID_UsesHiLo=1 throughout → 4 stall cycles, then release.
- Overlap and reset: MD_Start during busy → MD_Overlap=1, countdown unaffected. Reset pulse low mid-busy → MD_Busy=0, MD_Overlap=0, Stall_Cycles=0.
- Saturation: force Stall_Cycles to 32'hFFFF_FFFE, apply 3 stall cycles → holds at 32'hFFFF_FFFF.
